// File: rtl/fp_add_arbiter.sv
// ============================================================================
// Module  : fp_add_arbiter (with its combinational fp_add core)
// Brief   : Round-robin sharing of one fp_add among NUM_REQ requesters,
//           two-stage registered pipeline with a backpressured response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROUND_TYPE_WIDTH
`define ROUND_TYPE_WIDTH 3
`define ROUND_RTNE 3'd0
`define ROUND_RTZ  3'd1
`define ROUND_RDN  3'd2
`define ROUND_RUP  3'd3
`define ROUND_RMM  3'd4
`endif

module fp_add #(
    parameter int FP_WIDTH  = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic [FP_WIDTH-1:0]          in1_i,
    input  logic [FP_WIDTH-1:0]          in2_i,
    input  logic [`ROUND_TYPE_WIDTH-1:0] round_i,
    output logic [FP_WIDTH-1:0]          out_o
);
    localparam int                   c_W       = MAN_WIDTH + 4;
    localparam int                   c_EW      = EXP_WIDTH + 2;
    localparam logic [c_W-1:0]       c_ONE     = {{(c_W-1){1'b0}}, 1'b1};
    localparam logic [c_EW-1:0]      c_E1      = {{(c_EW-1){1'b0}}, 1'b1};
    localparam logic [EXP_WIDTH-1:0] c_EXP_MAX = '1;
    localparam logic [EXP_WIDTH-1:0] c_EXP_BIG = {{(EXP_WIDTH-1){1'b1}}, 1'b0};

    logic                 w_swap, w_sx, w_sy, w_sign, w_inc, w_sticky, w_eff_sub, w_to_max;
    logic [FP_WIDTH-1:0]  w_x, w_y;
    logic [EXP_WIDTH-1:0] w_ex, w_ey, w_ex_eff, w_ey_eff, w_diff;
    logic [c_W-1:0]       w_mx, w_my, w_my_sh, w_norm;
    logic [c_W:0]         w_sum;
    logic [c_EW-1:0]      w_exp;
    logic [MAN_WIDTH+1:0] w_mant;

    always_comb begin
        // x is always the operand of larger magnitude, so the difference is non-negative
        w_swap   = in2_i[FP_WIDTH-2:0] > in1_i[FP_WIDTH-2:0];
        w_x      = w_swap ? in2_i : in1_i;
        w_y      = w_swap ? in1_i : in2_i;
        w_sx     = w_x[FP_WIDTH-1];
        w_sy     = w_y[FP_WIDTH-1];
        w_ex     = w_x[FP_WIDTH-2 -: EXP_WIDTH];
        w_ey     = w_y[FP_WIDTH-2 -: EXP_WIDTH];
        w_mx     = {|w_ex, w_x[MAN_WIDTH-1:0], 3'b000};
        w_my     = {|w_ey, w_y[MAN_WIDTH-1:0], 3'b000};
        w_ex_eff = (w_ex == '0) ? {{(EXP_WIDTH-1){1'b0}}, 1'b1} : w_ex;
        w_ey_eff = (w_ey == '0) ? {{(EXP_WIDTH-1){1'b0}}, 1'b1} : w_ey;
        w_diff   = w_ex_eff - w_ey_eff;
        if (32'(w_diff) >= c_W) begin
            w_my_sh  = '0;
            w_sticky = |w_my;
        end else begin
            w_my_sh  = w_my >> w_diff;
            w_sticky = |(w_my & ((c_ONE << w_diff) - c_ONE));
        end
        w_my_sh[0] = w_my_sh[0] | w_sticky;
        w_eff_sub  = w_sx ^ w_sy;
        w_sum      = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my_sh}) : ({1'b0, w_mx} + {1'b0, w_my_sh});
        w_exp      = {2'b00, w_ex_eff};
        if (w_sum[c_W]) begin
            w_norm = {w_sum[c_W:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + c_E1;
        end else begin
            w_norm = w_sum[c_W-1:0];
            // left-normalise, stopping at the minimum exponent to produce subnormals
            for (int i = 0; i < c_W; i++) begin
                if (!w_norm[c_W-1] && (w_exp > c_E1)) begin
                    w_norm = w_norm << 1;
                    w_exp  = w_exp - c_E1;
                end
            end
        end
        w_sign = (w_sum == '0) ? (w_eff_sub ? (round_i == `ROUND_RDN) : w_sx) : w_sx;
        case (round_i)
            `ROUND_RTZ: w_inc = 1'b0;
            `ROUND_RDN: w_inc = w_sign & (w_norm[2] | (|w_norm[1:0]));
            `ROUND_RUP: w_inc = ~w_sign & (w_norm[2] | (|w_norm[1:0]));
            `ROUND_RMM: w_inc = w_norm[2];
            default:    w_inc = w_norm[2] & ((|w_norm[1:0]) | w_norm[3]);
        endcase
        w_mant = {1'b0, w_norm[c_W-1:3]} + {{(MAN_WIDTH+1){1'b0}}, w_inc};
        if (w_mant[MAN_WIDTH+1]) begin
            w_mant = w_mant >> 1;
            w_exp  = w_exp + c_E1;
        end
        w_to_max = (round_i == `ROUND_RTZ) || ((round_i == `ROUND_RDN) && !w_sign) ||
                   ((round_i == `ROUND_RUP) && w_sign);
        if (w_exp >= {2'b00, c_EXP_MAX}) begin
            out_o = w_to_max ? {w_sign, c_EXP_BIG, {MAN_WIDTH{1'b1}}}
                             : {w_sign, c_EXP_MAX, {MAN_WIDTH{1'b0}}};
        end else begin
            out_o = {w_sign, (w_mant[MAN_WIDTH] ? w_exp[EXP_WIDTH-1:0] : {EXP_WIDTH{1'b0}}),
                     w_mant[MAN_WIDTH-1:0]};
        end
        if (w_ex == c_EXP_MAX) begin
            out_o = ((|w_x[MAN_WIDTH-1:0]) || ((w_ey == c_EXP_MAX) && w_eff_sub))
                  ? {1'b0, c_EXP_MAX, 1'b1, {(MAN_WIDTH-1){1'b0}}} : w_x;
        end
    end
endmodule

module fp_add_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  FP_WIDTH  = 32,
    parameter int  EXP_WIDTH = 8,
    parameter int  MAN_WIDTH = 23,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NUM_REQ-1:0]                   REQ_VALID,
    output logic [NUM_REQ-1:0]                   REQ_READY,
    input  logic [NUM_REQ*FP_WIDTH-1:0]          REQ_IN1,
    input  logic [NUM_REQ*FP_WIDTH-1:0]          REQ_IN2,
    input  logic [NUM_REQ*`ROUND_TYPE_WIDTH-1:0] REQ_ROUND,
    output logic                                 RSP_VALID,
    input  logic                                 RSP_READY,
    output logic [FP_WIDTH-1:0]                  RSP_OUT,
    output logic [ID_WIDTH-1:0]                  RSP_ID,
    output logic [31:0]                          OP_COUNT
);
    logic [ID_WIDTH-1:0]          ptr_q, ptr_d, w_gid;
    logic [NUM_REQ-1:0]           w_grant;
    logic                         w_found, w_stall1, w_stall2, w_accept;
    int                           w_idx;
    logic                         v1_q, v2_q;
    logic [ID_WIDTH-1:0]          id1_q, id2_q;
    logic [FP_WIDTH-1:0]          in1_q, in2_q, out2_q, w_sum;
    logic [`ROUND_TYPE_WIDTH-1:0] round1_q;
    logic [31:0]                  count_q, count_d;

    assign w_stall2  = v2_q & ~RSP_READY;
    assign w_stall1  = v1_q & w_stall2;
    assign w_accept  = ~w_stall1 & ~RST;
    assign REQ_READY = {NUM_REQ{w_accept}} & w_grant;

    // first valid requester found scanning upward from ptr_q, wrapping at NUM_REQ
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(ptr_q) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && REQ_VALID[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gid          = ID_WIDTH'(w_idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_accept && w_found) begin
            ptr_d = (w_gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gid + ID_WIDTH'(1);
        end
        count_d = (RSP_VALID && RSP_READY) ? count_q + 32'd1 : count_q;
    end

    fp_add #(
        .FP_WIDTH  (FP_WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_fp_add (
        .in1_i   (in1_q),
        .in2_i   (in2_q),
        .round_i (round1_q),
        .out_o   (w_sum)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q    <= '0;
            count_q  <= '0;
            v1_q     <= 1'b0;
            id1_q    <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            round1_q <= '0;
            v2_q     <= 1'b0;
            id2_q    <= '0;
            out2_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (w_accept) begin
                v1_q     <= w_found;
                id1_q    <= w_gid;
                in1_q    <= REQ_IN1[w_gid*FP_WIDTH +: FP_WIDTH];
                in2_q    <= REQ_IN2[w_gid*FP_WIDTH +: FP_WIDTH];
                round1_q <= REQ_ROUND[w_gid*`ROUND_TYPE_WIDTH +: `ROUND_TYPE_WIDTH];
            end
            if (!w_stall2) begin
                v2_q   <= v1_q;
                id2_q  <= id1_q;
                out2_q <= w_sum;
            end
        end
    end

    assign RSP_VALID = v2_q;
    assign RSP_ID    = id2_q;
    assign RSP_OUT   = out2_q;
    assign OP_COUNT  = count_q;
endmodule

`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
// ============================================================================
// Module  : tb_fp_add_arbiter
// Brief   : Randomised self-checking bench for fp_add_arbiter against a
//           capacity/latency scoreboard and exact half-integer FP sums.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROUND_TYPE_WIDTH
`define ROUND_TYPE_WIDTH 3
`define ROUND_RTNE 3'd0
`define ROUND_RTZ  3'd1
`define ROUND_RDN  3'd2
`define ROUND_RUP  3'd3
`define ROUND_RMM  3'd4
`endif

module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int FW = 32;
    localparam int RW = `ROUND_TYPE_WIDTH;
    localparam int IW = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    REQ_VALID = '0;
    logic [N-1:0]    REQ_READY;
    logic [N*FW-1:0] REQ_IN1 = '0;
    logic [N*FW-1:0] REQ_IN2 = '0;
    logic [N*RW-1:0] REQ_ROUND = '0;
    logic            RSP_VALID;
    logic            RSP_READY = 1'b0;
    logic [FW-1:0]   RSP_OUT;
    logic [IW-1:0]   RSP_ID;
    logic [31:0]     OP_COUNT;

    fp_add_arbiter #(.NUM_REQ(N), .FP_WIDTH(FW), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_IN1(REQ_IN1), .REQ_IN2(REQ_IN2), .REQ_ROUND(REQ_ROUND),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_OUT(RSP_OUT),
        .RSP_ID(RSP_ID), .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct { int id; logic [31:0] val; int rdy; } ent_t;
    ent_t        exp_q[$];
    int          glog[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          m_ptr = 0;
    int          gen_pct = 0;
    int          rdy_mode = 0;
    logic [31:0] m_count = '0;
    logic        rst_now = 1'b1;
    logic        pend [N];
    logic [31:0] p_a [N], p_b [N], p_s [N];
    logic [RW-1:0] p_r [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, want);
        end
    endtask

    // exact single-precision encoding of h/2 (|h| small)
    function automatic logic [31:0] to_fp(input int h);
        int m, p;
        logic [31:0] r;
        if (h == 0) return 32'h0;
        m = (h < 0) ? -h : h;
        p = 0;
        for (int k = 0; k < 31; k++) if ((m >> k) != 0) p = k;
        r[31]    = (h < 0);
        r[30:23] = 8'(126 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] s, input logic [RW-1:0] r);
        pend[i] = 1'b1; p_a[i] = a; p_b[i] = b; p_s[i] = s; p_r[i] = r;
    endtask

    task automatic rand_req(input int i);
        int ha, hb;
        logic [RW-1:0] r;
        logic [31:0] s;
        ha = int'($urandom_range(4000)) - 2000;
        hb = int'($urandom_range(4000)) - 2000;
        r  = RW'($urandom_range(4));
        s  = to_fp(ha + hb);
        // exact cancellation of opposite signs is -0 only when rounding down
        if ((ha + hb == 0) && (ha != 0) && (r == RW'(`ROUND_RDN))) s = 32'h8000_0000;
        set_req(i, to_fp(ha), to_fp(hb), s, r);
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic int glog_at(input int k);
        return (k < glog.size()) ? glog[k] : -1;
    endfunction

    task automatic run_cycle();
        int g;
        logic [N-1:0] er;
        logic ev;
        @(negedge CLK);
        for (int i = 0; i < N; i++)
            if (!pend[i] && gen_pct > 0 && int'($urandom_range(99)) < gen_pct) rand_req(i);
        for (int i = 0; i < N; i++) begin
            REQ_VALID[i]            = pend[i];
            REQ_IN1[i*FW +: FW]     = pend[i] ? p_a[i] : 32'h0;
            REQ_IN2[i*FW +: FW]     = pend[i] ? p_b[i] : 32'h0;
            REQ_ROUND[i*RW +: RW]   = pend[i] ? p_r[i] : '0;
        end
        RST       = rst_now;
        RSP_READY = rst_now ? 1'b0 : (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(1));
        #1;
        for (int i = 0; i < N; i++) if (REQ_READY[i]) glog.push_back(i);
        if (rst_now) begin
            chk("ready_in_reset", 64'(REQ_READY), 64'd0);
            exp_q.delete();
            m_ptr   = 0;
            m_count = '0;
        end else begin
            g  = exp_grant();
            er = (g >= 0 && !((exp_q.size() == 2) && !RSP_READY)) ? N'(1 << g) : '0;
            ev = (exp_q.size() > 0) && (cycle >= exp_q[0].rdy);
            chk("req_ready", 64'(REQ_READY), 64'(er));
            chk("rsp_valid", 64'(RSP_VALID), 64'(ev));
            if (ev) begin
                chk("rsp_out", 64'(RSP_OUT), 64'(exp_q[0].val));
                chk("rsp_id", 64'(RSP_ID), 64'(exp_q[0].id));
            end
            chk("op_count", 64'(OP_COUNT), 64'(m_count));
            if (ev && RSP_READY) begin
                void'(exp_q.pop_front());
                m_count = m_count + 32'd1;
            end
            if (er != '0) begin
                exp_q.push_back('{g, p_s[g], cycle + 2});
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
            end
        end
        @(posedge CLK);
        cycle++;
    endtask

    task automatic do_reset(input int n);
        rst_now = 1'b1;
        repeat (n) run_cycle();
        rst_now = 1'b0;
        #1;
        chk("rst_valid", 64'(RSP_VALID), 64'd0);
        chk("rst_out", 64'(RSP_OUT), 64'd0);
        chk("rst_id", 64'(RSP_ID), 64'd0);
        chk("rst_count", 64'(OP_COUNT), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_a[i] = '0; p_b[i] = '0; p_s[i] = '0; p_r[i] = '0;
        end
        do_reset(2);

        // single add, latency and count
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, RW'(`ROUND_RTNE));
        repeat (5) run_cycle();
        #1 chk("single_count", 64'(OP_COUNT), 64'd1);

        // fairness with all requesters continuously valid
        do_reset(1);
        glog.delete();
        gen_pct = 100;
        repeat (8) run_cycle();
        gen_pct = 0;
        for (int k = 0; k < 8; k++) chk("fair_order", 64'(glog_at(k)), 64'(k % 4));
        repeat (8) run_cycle();

        // pointer moves past the last grant
        do_reset(1);
        glog.delete();
        rand_req(2);
        run_cycle();
        rand_req(0);
        rand_req(3);
        repeat (6) run_cycle();
        chk("ptr_first", 64'(glog_at(0)), 64'd2);
        chk("ptr_second", 64'(glog_at(1)), 64'd3);
        chk("ptr_third", 64'(glog_at(2)), 64'd0);

        // backpressure on a continuous stream
        do_reset(1);
        gen_pct = 100;
        repeat (3) run_cycle();
        rdy_mode = 1;
        repeat (5) run_cycle();
        rdy_mode = 0;
        repeat (4) run_cycle();
        gen_pct = 0;
        repeat (8) run_cycle();
        #1 chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // signed and mixed operands
        do_reset(1);
        set_req(1, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, RW'(`ROUND_RTNE));
        set_req(2, 32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000, RW'(`ROUND_RTNE));
        repeat (6) run_cycle();

        // reset with two operations in flight
        do_reset(1);
        gen_pct = 100;
        repeat (3) run_cycle();
        gen_pct = 0;
        do_reset(1);
        glog.delete();
        repeat (8) run_cycle();
        chk("post_rst_grant", 64'(glog_at(0)), 64'd0);

        // randomised traffic
        for (int blk = 0; blk < 14; blk++) begin
            gen_pct  = int'($urandom_range(100));
            rdy_mode = int'($urandom_range(2));
            repeat (150) run_cycle();
            if (blk == 7) do_reset(1);
        end
        gen_pct  = 0;
        rdy_mode = 0;
        repeat (12) run_cycle();
        #1 chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
